// File: rtl/mem_port_arbiter_pkg.sv
//==============================================================================
// Module      : arb_pkg
// Description : Shared state encoding and select constants for mem_port_arbiter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

`ifndef WORD
`define WORD 32
`endif

package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
//==============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester and shared-port handshake bundle for mem_port_arbiter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int WIDTH = `WORD
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_lock;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_lock;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             out_sel;
    logic             grant_a;
    logic             grant_b;

    // Master drives the requesters and the downstream ready.
    modport master (
        output a_valid, a_data, a_lock, b_valid, b_data, b_lock, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_sel, grant_a, grant_b
    );

    modport slave (
        input  a_valid, a_data, a_lock, b_valid, b_data, b_lock, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_sel, grant_a, grant_b
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_mux.sv
//==============================================================================
// Module      : mux
// Description : Two-input data selector; control selects b_in when SEL_B.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module mux
    import arb_pkg::*;
#(
    parameter int WIDTH = `WORD
) (
    input  wire logic [WIDTH-1:0] a_in,
    input  wire logic [WIDTH-1:0] b_in,
    input  wire logic             control,
    output logic      [WIDTH-1:0] mux_out
);

    assign mux_out = (control == SEL_B) ? b_in : a_in;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin two-requester arbiter with bounded burst lock.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH    = `WORD,
    parameter int MAX_HOLD = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);

    localparam int                CNT_W      = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  HOLD_MAX   = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0]  HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

    arb_state_t        state_q, state_d;
    logic              last_sel_q, last_sel_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic              out_sel_q, out_sel_d;
    logic              grant_a_q, grant_a_d;
    logic              grant_b_q, grant_b_d;

    logic              cur_valid;
    logic              cur_lock;
    logic              cur_sel;
    logic              oth_valid;
    arb_state_t        oth_state;
    logic              transfer;
    logic              release_now;
    logic [WIDTH-1:0]  mux_out;

    // Owner-relative views so both OWN states share one release path.
    assign cur_valid = (state_q == OWN_B) ? bus.b_valid : bus.a_valid;
    assign cur_lock  = (state_q == OWN_B) ? bus.b_lock  : bus.a_lock;
    assign cur_sel   = (state_q == OWN_B) ? SEL_B       : SEL_A;
    assign oth_valid = (state_q == OWN_B) ? bus.a_valid : bus.b_valid;
    assign oth_state = (state_q == OWN_B) ? OWN_A       : OWN_B;

    always_comb begin
        state_d     = state_q;
        last_sel_d  = last_sel_q;
        hold_cnt_d  = hold_cnt_q;
        transfer    = 1'b0;
        release_now = 1'b0;
        bus.a_ready   = 1'b0;
        bus.b_ready   = 1'b0;
        bus.out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (bus.a_valid && bus.b_valid) begin
                    state_d = (last_sel_q == SEL_B) ? OWN_A : OWN_B;
                end else if (bus.a_valid) begin
                    state_d = OWN_A;
                end else if (bus.b_valid) begin
                    state_d = OWN_B;
                end
            end
            OWN_A, OWN_B: begin
                bus.out_valid = cur_valid;
                bus.a_ready   = (state_q == OWN_A) && bus.out_ready;
                bus.b_ready   = (state_q == OWN_B) && bus.out_ready;
                transfer      = cur_valid && bus.out_ready;
                // A stalled beat pins ownership until it is accepted.
                if (transfer || !cur_valid) begin
                    release_now = !cur_lock || (hold_cnt_q >= HOLD_LIMIT);
                end
                if (release_now) begin
                    last_sel_d = cur_sel;
                    hold_cnt_d = '0;
                    if (oth_valid) begin
                        state_d = oth_state;
                    end else if (cur_valid) begin
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_sel_d = out_sel_q;
        if (state_d == OWN_A) begin
            out_sel_d = SEL_A;
        end else if (state_d == OWN_B) begin
            out_sel_d = SEL_B;
        end
        grant_a_d = (state_d == OWN_A);
        grant_b_d = (state_d == OWN_B);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_sel_q <= SEL_B;
            hold_cnt_q <= '0;
            out_sel_q  <= SEL_A;
            grant_a_q  <= 1'b0;
            grant_b_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_sel_q <= last_sel_d;
            hold_cnt_q <= hold_cnt_d;
            out_sel_q  <= out_sel_d;
            grant_a_q  <= grant_a_d;
            grant_b_q  <= grant_b_d;
        end
    end

    mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a_in    (bus.a_data),
        .b_in    (bus.b_data),
        .control (out_sel_q),
        .mux_out (mux_out)
    );

    assign bus.out_data = (state_q == IDLE) ? '0 : mux_out;
    assign bus.out_sel  = out_sel_q;
    assign bus.grant_a  = grant_a_q;
    assign bus.grant_b  = grant_b_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

`ifndef WORD
`define WORD 32
`endif

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [`WORD-1:0] neg_val;

    mem_port_arbiter_if #(.WIDTH(`WORD)) bus ();
    mem_port_arbiter_if #(.WIDTH(5))     bus5 ();

    mem_port_arbiter #(.WIDTH(`WORD), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_port_arbiter #(.WIDTH(5), .MAX_HOLD(4)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        neg_val = -350;
        bus.a_valid = 0; bus.a_data = 0; bus.a_lock = 0;
        bus.b_valid = 0; bus.b_data = 0; bus.b_lock = 0;
        bus.out_ready = 0;
        bus5.a_valid = 0; bus5.a_data = 0; bus5.a_lock = 0;
        bus5.b_valid = 0; bus5.b_data = 0; bus5.b_lock = 0;
        bus5.out_ready = 0;

        repeat (2) @(posedge clk);
        #2 reset = 0;
        #1;
        chk("rst_out_sel",   64'(bus.out_sel),   64'd0);
        chk("rst_grant_a",   64'(bus.grant_a),   64'd0);
        chk("rst_grant_b",   64'(bus.grant_b),   64'd0);
        chk("rst_a_ready",   64'(bus.a_ready),   64'd0);
        chk("rst_b_ready",   64'(bus.b_ready),   64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);

        // Both valid, no lock: A wins the first tie, then strict alternation.
        bus.a_valid = 1; bus.b_valid = 1; bus.a_data = 5; bus.b_data = 10; bus.out_ready = 1;
        #1;
        chk("alt_idle_valid", 64'(bus.out_valid), 64'd0);
        chk("alt_idle_ready", 64'(bus.a_ready),   64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_data",  64'(bus.out_data),  (i % 2 == 1) ? 64'd10 : 64'd5);
            chk("alt_sel",   64'(bus.out_sel),   (i % 2 == 1) ? 64'd1  : 64'd0);
            chk("alt_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.a_valid = 0; bus.b_valid = 0;
        #1;
        tick();
        chk("alt_end_ga",    64'(bus.grant_a),   64'd0);
        chk("alt_end_gb",    64'(bus.grant_b),   64'd0);
        chk("alt_end_valid", 64'(bus.out_valid), 64'd0);

        // A alone for a single beat.
        bus.a_valid = 1; bus.a_data = 5;
        #1;
        chk("solo_pre_ga", 64'(bus.grant_a), 64'd0);
        tick();
        chk("solo_ga",      64'(bus.grant_a),  64'd1);
        chk("solo_data",    64'(bus.out_data), 64'd5);
        chk("solo_a_ready", 64'(bus.a_ready),  64'd1);
        chk("solo_b_ready", 64'(bus.b_ready),  64'd0);
        tick();
        bus.a_valid = 0;
        #1;
        chk("solo_drop_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("solo_end_ga",   64'(bus.grant_a),  64'd0);
        chk("solo_end_data", 64'(bus.out_data), 64'd0);

        // Locked burst from A is capped at MAX_HOLD beats while B waits.
        bus.a_valid = 1; bus.a_lock = 1; bus.a_data = 7; bus.b_data = 10;
        #1;
        tick();
        bus.b_valid = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("lock_ga",    64'(bus.grant_a),  64'd1);
            chk("lock_data",  64'(bus.out_data), 64'd7);
            chk("lock_ready", 64'(bus.a_ready),  64'd1);
            tick();
        end
        chk("lock_gb",      64'(bus.grant_b),  64'd1);
        chk("lock_sel",     64'(bus.out_sel),  64'd1);
        chk("lock_b_data",  64'(bus.out_data), 64'd10);
        chk("lock_b_ready", 64'(bus.b_ready),  64'd1);
        tick();
        chk("lock_regain_ga", 64'(bus.grant_a), 64'd1);
        bus.a_valid = 0; bus.b_valid = 0; bus.a_lock = 0;
        #1;
        tick();
        chk("lock_end_ga", 64'(bus.grant_a), 64'd0);

        // Stall keeps A as owner with its beat held on the port.
        bus.a_valid = 1; bus.a_data = 3;
        #1;
        tick();
        bus.b_valid = 1; bus.out_ready = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_ga",      64'(bus.grant_a),   64'd1);
            chk("stall_data",    64'(bus.out_data),  64'd3);
            chk("stall_a_ready", 64'(bus.a_ready),   64'd0);
            chk("stall_valid",   64'(bus.out_valid), 64'd1);
            tick();
        end
        bus.out_ready = 1;
        #1;
        chk("stall_go_ready", 64'(bus.a_ready), 64'd1);
        tick();
        chk("stall_gb",     64'(bus.grant_b),  64'd1);
        chk("stall_b_data", 64'(bus.out_data), 64'd10);

        // Asynchronous reset in the middle of B's ownership.
        #1 reset = 1;
        #1;
        chk("mid_rst_gb",    64'(bus.grant_b),   64'd0);
        chk("mid_rst_ga",    64'(bus.grant_a),   64'd0);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_data",  64'(bus.out_data),  64'd0);
        chk("mid_rst_ready", 64'(bus.b_ready),   64'd0);
        chk("mid_rst_sel",   64'(bus.out_sel),   64'd0);
        tick();
        reset = 0;
        #1;
        chk("post_rst_idle", 64'(bus.grant_a), 64'd0);
        tick();
        chk("post_rst_tie_ga", 64'(bus.grant_a),  64'd1);
        chk("post_rst_data",   64'(bus.out_data), 64'd3);
        chk("post_rst_sel",    64'(bus.out_sel),  64'd0);
        bus.a_valid = 0; bus.b_valid = 0;
        #1;
        tick();

        // Sign-bit payload and a narrow instance.
        bus.b_valid = 1; bus.b_data = neg_val;
        bus5.a_valid = 1; bus5.a_data = 5'd22; bus5.out_ready = 1;
        #1;
        tick();
        chk("neg_gb",    64'(bus.grant_b),   64'd1);
        chk("neg_data",  64'(bus.out_data),  64'(neg_val));
        chk("w5_ga",     64'(bus5.grant_a),  64'd1);
        chk("w5_data",   64'(bus5.out_data), 64'd22);
        bus.b_valid = 0; bus5.a_valid = 0;
        #1;
        tick();
        chk("final_idle_gb", 64'(bus.grant_b),  64'd0);
        chk("final_idle_w5", 64'(bus5.grant_a), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
